obuft_ser_drv: RTL and testbench

- Registered parallel-to-serial tristate pad driver, one stage upstream of the tristate output buffer primitive.
- Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per clock on O_I.
- Holds O_T low (drive enabled) for the data bits only, then inserts TURN bus-turnaround cycles with O_T high (hi-Z) before it accepts the next word.
- O_I and O_T come straight from flops, so they pack into the IOB and connect directly to the buffer's I and T pins.

---
 rtl/obuft_ser_pkg.sv | 19 +
 rtl/obuft_ser_drv.sv | 152 +++++++++++++++
 tb/tb_obuft_ser_drv.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/obuft_ser_pkg.sv
// Shared types and helpers for the obuft_ser_drv tristate serialiser.
package obuft_ser_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_TURN  = 2'd2
  } state_t;

  localparam logic OBUFT_T_HIZ = 1'b1;

  // Counter width for a count range of n; never narrower than one bit.
  function automatic int cnt_w(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/obuft_ser_drv.sv
// Registered parallel-to-serial tristate pad driver feeding an OBUFT's I/T pins.
// Optional back-to-back bursts without turnaround: define OBUFT_SER_DRV_BURST_EN.
module obuft_ser_drv
  import obuft_ser_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int TURN      = 1,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             CLK,
  input  logic             CLR_N,
  input  logic [WIDTH-1:0] D,
  input  logic             D_VALID,
  output logic             D_READY,
  output logic             O_I,
  output logic             O_T,
  output logic             BUSY,
  output logic             DONE
);

  localparam int CW = cnt_w((WIDTH > TURN) ? WIDTH : TURN);
  localparam logic [CW-1:0] LAST_BIT  = CW'(WIDTH - 1);
  localparam logic [CW-1:0] LAST_TURN = CW'(TURN - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_nxt;
  logic [WIDTH-1:0] r_shreg;
  logic [WIDTH-1:0] w_shreg_nxt;
  logic             r_o_i;
  logic             w_o_i_nxt;
  logic             r_o_t;
  logic             w_o_t_nxt;
  logic             r_done;
  logic             w_done_nxt;

  logic             w_last_bit;
  logic             w_accept;
  logic             w_first_bit;
  logic [WIDTH-1:0] w_d_rest;
  logic             w_next_bit;
  logic [WIDTH-1:0] w_sh_rest;

  // Handshake: a word transfers on a rising CLK edge where D_VALID and
  // D_READY are both high; D_READY depends on state only, never on D_VALID.
  assign w_last_bit = (r_state == ST_SHIFT) && (r_cnt == LAST_BIT);
`ifdef OBUFT_SER_DRV_BURST_EN
  assign D_READY = (r_state == ST_IDLE) || w_last_bit;
`else
  assign D_READY = (r_state == ST_IDLE);
`endif
  assign w_accept = D_VALID && D_READY;

  // The first bit goes straight into the output flop at accept, so the
  // shift register only holds the bits still to come.
  generate
    if (LSB_FIRST) begin : g_lsb
      assign w_first_bit = D[0];
      assign w_d_rest    = D >> 1;
      assign w_next_bit  = r_shreg[0];
      assign w_sh_rest   = r_shreg >> 1;
    end else begin : g_msb
      assign w_first_bit = D[WIDTH-1];
      assign w_d_rest    = D << 1;
      assign w_next_bit  = r_shreg[WIDTH-1];
      assign w_sh_rest   = r_shreg << 1;
    end
  endgenerate

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_shreg_nxt = r_shreg;
    w_o_i_nxt   = r_o_i;
    w_o_t_nxt   = r_o_t;
    w_done_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_o_t_nxt = OBUFT_T_HIZ;
        w_o_i_nxt = 1'b0;
        if (w_accept) begin
          w_state_nxt = ST_SHIFT;
          w_cnt_nxt   = '0;
          w_shreg_nxt = w_d_rest;
          w_o_i_nxt   = w_first_bit;
          w_o_t_nxt   = ~OBUFT_T_HIZ;
        end
      end
      ST_SHIFT: begin
        w_o_t_nxt = ~OBUFT_T_HIZ;
        if (w_last_bit) begin
          if (w_accept) begin
            w_cnt_nxt   = '0;
            w_shreg_nxt = w_d_rest;
            w_o_i_nxt   = w_first_bit;
          end else begin
            w_state_nxt = ST_TURN;
            w_cnt_nxt   = '0;
            w_o_t_nxt   = OBUFT_T_HIZ;
            w_o_i_nxt   = 1'b0;
            w_done_nxt  = 1'b1;
          end
        end else begin
          w_cnt_nxt   = r_cnt + CW'(1);
          w_shreg_nxt = w_sh_rest;
          w_o_i_nxt   = w_next_bit;
        end
      end
      ST_TURN: begin
        w_o_t_nxt = OBUFT_T_HIZ;
        w_o_i_nxt = 1'b0;
        if (r_cnt == LAST_TURN) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
        w_o_t_nxt   = OBUFT_T_HIZ;
        w_o_i_nxt   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_shreg <= '0;
      r_o_i   <= 1'b0;
      r_o_t   <= OBUFT_T_HIZ;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_shreg <= w_shreg_nxt;
      r_o_i   <= w_o_i_nxt;
      r_o_t   <= w_o_t_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign O_I  = r_o_i;
  assign O_T  = r_o_t;
  assign DONE = r_done;
  assign BUSY = (r_state != ST_IDLE);

endmodule

// File: tb/tb_obuft_ser_drv.sv
// Directed bench for obuft_ser_drv: WIDTH=8, TURN=2, one LSB-first and one MSB-first instance.
module tb_obuft_ser_drv;

  logic       clk = 1'b0;
  logic       clr_n;
  logic [7:0] d_l, d_m;
  logic       v_l, v_m;
  logic       rdy_l, oi_l, ot_l, busy_l, done_l;
  logic       rdy_m, oi_m, ot_m, busy_m, done_m;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  obuft_ser_drv #(.WIDTH(8), .TURN(2), .LSB_FIRST(1'b1)) u_lsb (
    .CLK(clk), .CLR_N(clr_n), .D(d_l), .D_VALID(v_l), .D_READY(rdy_l),
    .O_I(oi_l), .O_T(ot_l), .BUSY(busy_l), .DONE(done_l)
  );

  obuft_ser_drv #(.WIDTH(8), .TURN(2), .LSB_FIRST(1'b0)) u_msb (
    .CLK(clk), .CLR_N(clr_n), .D(d_m), .D_VALID(v_m), .D_READY(rdy_m),
    .O_I(oi_m), .O_T(ot_m), .BUSY(busy_m), .DONE(done_m)
  );

  typedef struct {
    logic       valid;
    logic [7:0] d;
    logic       rdy;
    logic       t;
    logic       i;
    logic       done;
    logic       busy;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge: sends d on the selected instance and checks the
  // whole driven window, the two turnaround cycles and the return to idle.
  task automatic send_word(input bit msb, input logic [7:0] d, input logic [7:0] exp_seq,
                           input string tag);
    int waited = 0;
    while (!(msb ? rdy_m : rdy_l) && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    chk($sformatf("%s ready_before", tag), msb ? rdy_m : rdy_l, 1);
    if (msb) begin d_m = d; v_m = 1'b1; end
    else     begin d_l = d; v_l = 1'b1; end
    @(negedge clk);
    if (msb) begin d_m = ~d; v_m = 1'b0; end
    else     begin d_l = ~d; v_l = 1'b0; end
    for (int b = 0; b < 8; b++) begin
      if (b > 0) @(negedge clk);
      chk($sformatf("%s o_t bit%0d", tag, b), msb ? ot_m : ot_l, 0);
      chk($sformatf("%s o_i bit%0d", tag, b), msb ? oi_m : oi_l, exp_seq[7-b]);
    end
    @(negedge clk);
    chk($sformatf("%s turn1 o_t", tag), msb ? ot_m : ot_l, 1);
    chk($sformatf("%s turn1 o_i", tag), msb ? oi_m : oi_l, 0);
    chk($sformatf("%s turn1 done", tag), msb ? done_m : done_l, 1);
    @(negedge clk);
    chk($sformatf("%s turn2 o_t", tag), msb ? ot_m : ot_l, 1);
    chk($sformatf("%s turn2 done", tag), msb ? done_m : done_l, 0);
    @(negedge clk);
    chk($sformatf("%s ready_after", tag), msb ? rdy_m : rdy_l, 1);
    chk($sformatf("%s busy_after", tag), msb ? busy_m : busy_l, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  a5;
    logic [29:0] lt, li, ldn;
    logic [15:0] got_bits;
    int          n_acc, nd, first_d, last_d, n_done;
    logic        take;

    // Reset held with D_VALID asserted: nothing may be accepted.
    clr_n = 1'b0; v_l = 1'b1; v_m = 1'b1; d_l = 8'hFF; d_m = 8'hFF;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("rst%0d o_t", c), ot_l, 1);
      chk($sformatf("rst%0d o_i", c), oi_l, 0);
      chk($sformatf("rst%0d busy", c), busy_l, 0);
      chk($sformatf("rst%0d done", c), done_l, 0);
      chk($sformatf("rst%0d ready", c), rdy_l, 1);
      chk($sformatf("rst%0d msb o_t", c), ot_m, 1);
    end
    v_l = 1'b0; v_m = 1'b0;
    clr_n = 1'b1;
    @(negedge clk);
    chk("post_rst ready", rdy_l, 1);
    chk("post_rst busy", busy_l, 0);
    chk("post_rst o_t", ot_l, 1);

    // Single word 0xA5, LSB first, as a per-cycle vector table.
    a5 = 8'hA5;
    vecs.push_back('{valid: 1'b1, d: 8'hA5, rdy: 1'b1, t: 1'b1, i: 1'b0, done: 1'b0, busy: 1'b0});
    for (int b = 0; b < 8; b++)
      vecs.push_back('{valid: 1'b0, d: 8'h3C + 8'(b), rdy: 1'b0, t: 1'b0, i: a5[b],
                       done: 1'b0, busy: 1'b1});
    vecs.push_back('{valid: 1'b1, d: 8'hFF, rdy: 1'b0, t: 1'b1, i: 1'b0, done: 1'b1, busy: 1'b1});
    vecs.push_back('{valid: 1'b1, d: 8'hFF, rdy: 1'b0, t: 1'b1, i: 1'b0, done: 1'b0, busy: 1'b1});
    vecs.push_back('{valid: 1'b0, d: 8'h00, rdy: 1'b1, t: 1'b1, i: 1'b0, done: 1'b0, busy: 1'b0});
    for (int r = 0; r < vecs.size(); r++) begin
      chk($sformatf("vec%0d ready", r), rdy_l, vecs[r].rdy);
      chk($sformatf("vec%0d o_t", r), ot_l, vecs[r].t);
      chk($sformatf("vec%0d o_i", r), oi_l, vecs[r].i);
      chk($sformatf("vec%0d done", r), done_l, vecs[r].done);
      chk($sformatf("vec%0d busy", r), busy_l, vecs[r].busy);
      v_l = vecs[r].valid;
      d_l = vecs[r].d;
      @(negedge clk);
    end

    // MSB-first instance.
    send_word(1'b1, 8'h81, 8'b1000_0001, "msb81");
    send_word(1'b1, 8'h01, 8'b0000_0001, "msb01");

    // Reset in the 4th SHIFT cycle of 0xFF.
    d_l = 8'hFF; v_l = 1'b1;
    @(negedge clk);
    v_l = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("midrst pre o_t", ot_l, 0);
    chk("midrst pre o_i", oi_l, 1);
    #2 clr_n = 1'b0;
    #1;
    chk("midrst o_t", ot_l, 1);
    chk("midrst o_i", oi_l, 0);
    chk("midrst busy", busy_l, 0);
    chk("midrst ready", rdy_l, 1);
    chk("midrst done", done_l, 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("midrst hold%0d done", c), done_l, 0);
      chk($sformatf("midrst hold%0d o_t", c), ot_l, 1);
    end
    clr_n = 1'b1;
    @(negedge clk);
    chk("midrst release done", done_l, 0);
    send_word(1'b0, 8'h3C, 8'b0011_1100, "after_rst3C");

    // Back-to-back: D_VALID held high across 0x11 then 0x22.
    v_l = 1'b1; d_l = 8'h11; n_acc = 0;
    for (int c = 0; c < 30; c++) begin
      lt[c]  = ot_l;
      li[c]  = oi_l;
      ldn[c] = done_l;
      take   = v_l && rdy_l;
      @(posedge clk);
      #1;
      if (take) begin
        n_acc++;
        if (n_acc == 1) d_l = 8'h22;
        else            v_l = 1'b0;
      end
      @(negedge clk);
    end
    nd = 0; first_d = -1; last_d = -1; n_done = 0; got_bits = '0;
    for (int c = 0; c < 30; c++) begin
      if (ldn[c]) n_done++;
      if (!lt[c]) begin
        if (nd < 16) got_bits[15-nd] = li[c];
        if (first_d < 0) first_d = c;
        last_d = c;
        nd++;
      end
    end
    chk("b2b accepts", n_acc, 2);
    chk("b2b driven cycles", nd, 16);
    chk("b2b bit stream", got_bits, 16'b1000_1000_0100_0100);
`ifdef OBUFT_SER_DRV_BURST_EN
    chk("b2b gap", (last_d - first_d + 1) - nd, 0);
    chk("b2b done pulses", n_done, 1);
`else
    chk("b2b gap", (last_d - first_d + 1) - nd, 3);
    chk("b2b done pulses", n_done, 2);
`endif
    chk("b2b final o_t", ot_l, 1);
    chk("b2b final busy", busy_l, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
